// File: rtl/rtc_pkg.sv
// Shared constants and types for the RTC read sequencer: register address
// table, command byte, sweep state encoding and small decode helpers.
package rtc_pkg;

    localparam int N_REGS = 9;
    localparam int IDX_W  = 4;

    localparam logic [7:0]       CMD_TRANSFER = 8'hF0;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_REGS - 1);

    // Entry i is read into display slot i (en_reg bit i).
    localparam logic [N_REGS-1:0][7:0] REG_ADDR = {
        8'h43, 8'h42, 8'h41,
        8'h26, 8'h25, 8'h24,
        8'h23, 8'h22, 8'h21
    };

    typedef enum logic [2:0] {
        IDLE,
        CMD_ADDR,
        CMD_REL,
        RD_ADDR,
        RD_REL,
        RD_DATA,
        CAPTURE,
        DONE
    } rtc_state_t;

    function automatic logic [7:0] reg_addr(input logic [IDX_W-1:0] idx);
        if (idx <= LAST_IDX) begin
            return REG_ADDR[idx];
        end
        return 8'h00;
    endfunction

    function automatic logic [N_REGS-1:0] reg_strobe(input logic [IDX_W-1:0] idx);
        return N_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Bus phase down-counter: reloads with PHASE_CYCLES-1 on every state change
// and flags the final cycle of the phase.
module phase_timer #(
    parameter int PHASE_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam int CNT_W = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PHASE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Saturates at zero so a state that ignores expire never wraps around.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= LOAD_VAL;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/rtc_read_sequencer.sv
// Sweeps the RTC chip: issues the transfer command, then reads nine
// time/timer registers and strobes each byte into the display register.
module rtc_read_sequencer
    import rtc_pkg::*;
#(
    parameter int PHASE_CYCLES = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic [7:0]        ad_in,
    output logic              cs_n,
    output logic              rd_n,
    output logic              wr_n,
    output logic              ad_n,
    output logic [7:0]        ad_out,
    output logic              ad_oe,
    output logic [7:0]        data_out,
    output logic [N_REGS-1:0] en_reg,
    output logic              busy,
    output logic              done
);

    rtc_state_t       state_q;
    rtc_state_t       state_d;
    logic [IDX_W-1:0] index_q;
    logic             phase_load;
    logic             phase_done;

    assign phase_load = (state_d != state_q);

    phase_timer #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_phase_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (phase_load),
        .expire (phase_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index_q <= '0;
        end else if (state_q == CAPTURE) begin
            index_q <= (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
        end
    end

    // Sample the bus on the final data-phase edge so data_out is valid in CAPTURE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= 8'h00;
        end else if ((state_q == RD_DATA) && phase_done) begin
            data_out <= ad_in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start && !pause) state_d = CMD_ADDR;
            CMD_ADDR: if (phase_done) state_d = CMD_REL;
            CMD_REL:  if (phase_done) state_d = RD_ADDR;
            RD_ADDR:  if (phase_done) state_d = RD_REL;
            RD_REL:   if (phase_done) state_d = RD_DATA;
            RD_DATA:  if (phase_done) state_d = CAPTURE;
            CAPTURE:  state_d = (index_q == LAST_IDX) ? DONE : RD_ADDR;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs decode straight from the state register, so reset releases the bus at once.
    always_comb begin
        cs_n   = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        ad_n   = 1'b1;
        ad_oe  = 1'b0;
        ad_out = 8'h00;
        en_reg = '0;
        busy   = (state_q != IDLE);
        done   = 1'b0;
        case (state_q)
            CMD_ADDR: begin
                cs_n   = 1'b0;
                wr_n   = 1'b0;
                ad_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = CMD_TRANSFER;
            end
            RD_ADDR: begin
                cs_n   = 1'b0;
                wr_n   = 1'b0;
                ad_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = reg_addr(index_q);
            end
            RD_DATA: begin
                cs_n = 1'b0;
                rd_n = 1'b0;
            end
            CAPTURE: begin
                en_reg = reg_strobe(index_q);
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/rtc_read_sequencer.md
# rtc_read_sequencer

Upstream feeder of the VGA display path. It periodically sweeps the external RTC chip over its multiplexed address/data bus and reads nine time/timer registers. Each byte goes out on `data_out` together with a one-hot `en_reg` strobe that loads the matching slot of the display data register. The sweep is started by the PicoBlaze or a refresh tick and can be paused while the PicoBlaze owns the registers.

## Interface
Parameters:
- PHASE_CYCLES, 10: clk cycles each bus phase is held. Legal minimum is 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle sweep request.
- pause  in  1  when 1, `start` is ignored (PicoBlaze owns the display registers).
- ad_in  in  8  RTC bus read-back.
- cs_n, rd_n, wr_n  out  1 each  RTC strobes, active-low.
- ad_n  out  1  bus phase select: 0 = address phase, 1 = data phase.
- ad_out  out  8  driven bus value.
- ad_oe  out  1  bus output enable.
- data_out  out  8  captured register byte.
- en_reg  out  9  one-hot load strobe for the display data register.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at end of sweep.

## Operation
- Reset value of every output:
  - cs_n = rd_n = wr_n = ad_n = 1.
  - ad_out = 0, ad_oe = 0.
  - data_out = 0, en_reg = 0.
  - busy = 0, done = 0.
- In IDLE, the sweep starts when `start` = 1 and `pause` = 0. Otherwise `start` is dropped.
- `start` while busy is ignored. Requests are not queued.
- Sweep order:
  - First, command write of 0xF0 (transfer time to the readable registers). This is an address phase only, with no data phase.
  - Then nine reads at these addresses, index → en_reg bit: 0x21 sec→0, 0x22 min→1, 0x23 hour→2, 0x24 day→3, 0x25 month→4, 0x26 year→5, 0x41 timer sec→6, 0x42 timer min→7, 0x43 timer hour→8.
- FSM states: IDLE → CMD_ADDR → CMD_REL → { RD_ADDR → RD_REL → RD_DATA → CAPTURE } ×9 → DONE → IDLE.
- Bus behaviour per state:
  - CMD_ADDR / RD_ADDR: cs_n = 0, wr_n = 0, ad_n = 0, ad_oe = 1, ad_out = address.
  - CMD_REL / RD_REL: all strobes high, ad_oe = 0.
  - RD_DATA: cs_n = 0, rd_n = 0, ad_n = 1, ad_oe = 0.
  - CAPTURE: strobes high. data_out ← ad_in as sampled in the last RD_DATA cycle; en_reg = 1 << index.
- Index is a 4-bit counter, 0..8. After index 8 is captured, the FSM goes to DONE and the counter clears to 0.
- `pause` rising mid-sweep has no effect. A started sweep always completes.
- en_reg is never multi-hot and never high outside CAPTURE.
- data_out holds its value between captures.

## Timing
- Let P = PHASE_CYCLES.
- `start` sampled at edge k → busy = 1 and CMD_ADDR from cycle k+1.
- Phase durations: ADDR, REL and DATA phases last exactly P cycles each. CAPTURE and DONE last 1 cycle each.
- Sweep length is 2P + 9(3P+1) = 29P + 9 cycles from busy rising to the DONE cycle (299 for P = 10).
- `done` = 1 for the single DONE cycle. busy falls in the cycle after DONE, so a new `start` is accepted in that cycle.
- en_reg and data_out are valid in the same cycle, so the downstream register loads at the next edge.
- Reset deassertion mid-sweep or assertion at any time:
  - all outputs go to their reset values immediately (asynchronous);
  - bus released;
  - index cleared;
  - no en_reg glitch.

## Structure
- Shared package `rtc_pkg` holds:
  - the address table (9 × 8-bit constants) and CMD_TRANSFER = 8'hF0;
  - the state enum;
  - N_REGS = 9.
- One sub-module, `phase_timer`: a down-counter loaded with P−1. It asserts `expire` on its last cycle and is reloaded on every state change.
- The FSM and index counter stay in `rtc_read_sequencer`.

## Test plan
- Reset, then hold idle 50 cycles → all outputs at reset values and strobes high.
- P = 10, one `start` pulse, RTC model returning address XOR 0x5A:
  - nine en_reg pulses in order bit 0..8;
  - data_out = 0x7B, 0x78, 0x79, 0x7E, 0x7F, 0x7C, 0x1B, 0x18, 0x19;
  - `done` exactly 299 cycles after busy rises.
- `start` with `pause` = 1 → no bus activity, busy stays 0. `pause` asserted mid-sweep → sweep completes with all nine captures.
- Extra `start` pulses during a sweep → exactly one sweep. `start` in the cycle after `done` → second sweep begins.
- Reset asserted during the RD_DATA phase of index 4 → outputs at reset values that same cycle. A new sweep restarts from the 0xF0 command.
- Bus protocol check each cycle:
  - ad_oe = 1 only when wr_n = 0;
  - rd_n and wr_n never both 0;
  - cs_n = 0 only in ADDR or DATA phases.
